// File: rtl/sha1_stream_ctrl.sv
// Byte-stream front end for a SHA-1 block-compression core: assembles big-endian
// 512-bit blocks, appends SHA-1 padding and bit length, and sequences the core.
module sha1_stream_ctrl #(
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned FEED_CYCLES  = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         in_ready,
    output logic         sha_reset,
    output logic         sha_feed,
    output logic [511:0] sha_message,
    input  logic         sha_done,
    input  logic [159:0] sha_hash,
    output logic [159:0] hash,
    output logic         hash_valid,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CRST,
        S_FILL,
        S_PAD,
        S_FEED,
        S_WAIT
    } state_t;

    localparam logic [15:0] RST_LOAD  = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] FEED_LOAD = 16'(FEED_CYCLES - 1);

    state_t         state_q;
    logic [511:0]   msg_q;
    logic [6:0]     idx_q;
    logic [31:0]    byte_cnt_q;
    logic [15:0]    cnt_q;
    logic           last_seen_q;
    logic           marker_q;
    logic           final_q;
    logic           pad_next_q;
    logic           in_ready_q;
    logic           sha_reset_q;
    logic           sha_feed_q;
    logic           hash_valid_q;
    logic           busy_q;
    logic [159:0]   hash_q;

    logic           accept;
    logic [511:0]   fill_msg_d;
    logic [511:0]   pad_msg_d;
    logic [63:0]    len_d;

    assign accept = in_valid && in_ready_q;
    assign len_d  = {29'b0, byte_cnt_q, 3'b000};

    // Per-byte views of the buffer: the incoming byte dropped at idx, and the
    // padded image (data below idx, marker at idx if not yet placed, zeros above).
    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_byte
            localparam int HI = 511 - 8 * gi;
            assign fill_msg_d[HI -: 8] = (idx_q == 7'(gi)) ? in_data : msg_q[HI -: 8];
            assign pad_msg_d[HI -: 8]  = (7'(gi) < idx_q) ? msg_q[HI -: 8] :
                                         ((7'(gi) == idx_q) && !marker_q) ? 8'h80 : 8'h00;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            msg_q        <= '0;
            idx_q        <= '0;
            byte_cnt_q   <= '0;
            cnt_q        <= '0;
            last_seen_q  <= 1'b0;
            marker_q     <= 1'b0;
            final_q      <= 1'b0;
            pad_next_q   <= 1'b0;
            in_ready_q   <= 1'b0;
            sha_reset_q  <= 1'b0;
            sha_feed_q   <= 1'b0;
            hash_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            hash_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    if (accept) begin
                        msg_q        <= {in_data, 504'b0};
                        idx_q        <= 7'd1;
                        byte_cnt_q   <= 32'd1;
                        last_seen_q  <= in_last;
                        marker_q     <= 1'b0;
                        final_q      <= 1'b0;
                        pad_next_q   <= 1'b0;
                        hash_valid_q <= 1'b0;
                        in_ready_q   <= 1'b0;
                        sha_reset_q  <= 1'b1;
                        cnt_q        <= RST_LOAD;
                        busy_q       <= 1'b1;
                        state_q      <= S_CRST;
                    end
                end

                S_CRST: begin
                    if (cnt_q == 16'd0) begin
                        sha_reset_q <= 1'b0;
                        if (last_seen_q) begin
                            state_q <= S_PAD;
                        end else begin
                            in_ready_q <= 1'b1;
                            state_q    <= S_FILL;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end

                S_FILL: begin
                    if (accept) begin
                        msg_q      <= fill_msg_d;
                        idx_q      <= idx_q + 7'd1;
                        byte_cnt_q <= byte_cnt_q + 32'd1;
                        if (in_last) begin
                            last_seen_q <= 1'b1;
                        end
                        if (idx_q == 7'd63) begin
                            // A full block goes out as-is; a final byte here defers padding.
                            in_ready_q <= 1'b0;
                            pad_next_q <= in_last;
                            sha_feed_q <= 1'b1;
                            cnt_q      <= FEED_LOAD;
                            state_q    <= S_FEED;
                        end else if (in_last) begin
                            in_ready_q <= 1'b0;
                            state_q    <= S_PAD;
                        end
                    end
                end

                S_PAD: begin
                    marker_q <= 1'b1;
                    if (marker_q || idx_q <= 7'd55) begin
                        msg_q   <= {pad_msg_d[511:64], len_d};
                        final_q <= 1'b1;
                    end else begin
                        msg_q <= pad_msg_d;
                    end
                    sha_feed_q <= 1'b1;
                    cnt_q      <= FEED_LOAD;
                    state_q    <= S_FEED;
                end

                S_FEED: begin
                    if (cnt_q == 16'd0) begin
                        sha_feed_q <= 1'b0;
                        state_q    <= S_WAIT;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end

                S_WAIT: begin
                    if (sha_done) begin
                        if (final_q) begin
                            hash_q       <= sha_hash;
                            hash_valid_q <= 1'b1;
                            in_ready_q   <= 1'b1;
                            busy_q       <= 1'b0;
                            state_q      <= S_IDLE;
                        end else begin
                            msg_q <= '0;
                            idx_q <= '0;
                            if (pad_next_q || marker_q) begin
                                pad_next_q <= 1'b0;
                                state_q    <= S_PAD;
                            end else begin
                                in_ready_q <= 1'b1;
                                state_q    <= S_FILL;
                            end
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign sha_reset   = sha_reset_q;
    assign sha_feed    = sha_feed_q;
    assign sha_message = msg_q;
    assign hash        = hash_q;
    assign hash_valid  = hash_valid_q;
    assign busy        = busy_q;

endmodule
